// File: rtl/alu_nbit_seq.sv
// alu_nbit_seq -- WIDTH-bit ALU with a registered result and a start/done handshake.
//   Single-cycle ops: ADD, SUB, XOR, SLT. Multi-cycle op: shift-add MUL (low WIDTH bits).
//   Optional flags: define ALU_SEQ_FLAGS_EN to add the zero/ovf outputs.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while ready=1
//   op[2:0]      000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 MUL, others reserved (result 0)
//   a, b         operands
//   ready        idle, a start will be accepted
//   done         one-cycle pulse, result valid
//   result       registered result, held until the next done
//   cout         carry out of ADD/SUB (SUB: 1 = no borrow), 0 otherwise
//   zero, ovf    (ALU_SEQ_FLAGS_EN only) result==0 / signed overflow (MUL: upper product bits nonzero)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; ready=1
// MUL   | one shift-add iteration per cycle, WIDTH cycles, fixed latency
// DONE  | result valid; done=1 for this single cycle

module alu_nbit_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  // The flag build keeps the full 2*WIDTH product so the overflow check can see the upper half.
`ifdef ALU_SEQ_FLAGS_EN
  localparam int AW = 2 * WIDTH;
`else
  localparam int AW = WIDTH;
`endif

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]    acc;
  logic [AW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_sub;
  logic             ovf_sub;
  logic             slt_bit;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic [AW-1:0]    acc_sum;
  logic             mul_last;
`ifdef ALU_SEQ_FLAGS_EN
  logic             ovf_add;
  logic             alu_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = (op == OP_MUL) ? S_MUL : S_DONE;
      end
      S_MUL:  if (mul_last) state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle ALU, evaluated on the live operands; they are consumed at the start edge.
  always_comb begin
    sum_add = {1'b0, a} + {1'b0, b};
    sum_sub = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    // SLT uses sign XOR overflow so it stays correct when a-b wraps.
    ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);
    slt_bit = sum_sub[WIDTH-1] ^ ovf_sub;
`ifdef ALU_SEQ_FLAGS_EN
    ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
    alu_ovf = 1'b0;
`endif
    alu_res  = '0;
    alu_cout = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res  = sum_add[WIDTH-1:0];
        alu_cout = sum_add[WIDTH];
`ifdef ALU_SEQ_FLAGS_EN
        alu_ovf  = ovf_add;
`endif
      end
      OP_SUB: begin
        alu_res  = sum_sub[WIDTH-1:0];
        alu_cout = sum_sub[WIDTH];
`ifdef ALU_SEQ_FLAGS_EN
        alu_ovf  = ovf_sub;
`endif
      end
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    acc_sum  = acc + (mplier[0] ? mcand : '0);
    mul_last = (cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      zero   <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              acc    <= '0;
              mcand  <= AW'(a);
              mplier <= b;
              cnt    <= '0;
            end else begin
              result <= alu_res;
              cout   <= alu_cout;
`ifdef ALU_SEQ_FLAGS_EN
              zero   <= (alu_res == '0);
              ovf    <= alu_ovf;
`endif
            end
          end
        end
        S_MUL: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (mul_last) begin
            result <= acc_sum[WIDTH-1:0];
            cout   <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            zero   <= (acc_sum[WIDTH-1:0] == '0);
            ovf    <= |acc_sum[AW-1:WIDTH];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nbit_seq.sv
module tb_alu_nbit_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, done, cout;
  logic [W-1:0] result;
`ifdef ALU_SEQ_FLAGS_EN
  logic         zero, ovf;
`endif

  alu_nbit_seq #(.WIDTH(W), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .done(done), .result(result), .cout(cout)
`ifdef ALU_SEQ_FLAGS_EN
    , .zero(zero), .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         zero;
    logic         ovf;
    int           cyc;
    string        name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: result %0h at cycle %0d with nothing outstanding", result, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_result"}, 32'(result), 32'(e.res));
        chk({e.name, "_cout"}, 32'(cout), 32'(e.cout));
        chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
`ifdef ALU_SEQ_FLAGS_EN
        chk({e.name, "_zero"}, 32'(zero), 32'(e.zero));
        chk({e.name, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  task automatic issue(input string name, input logic [2:0] o, input logic [W-1:0] x, y,
                       input bit push, input logic [W-1:0] er, input logic ec, ez, eo);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_ready_wait"}, 32'(ready), 32'(1));
    op = o; a = x; b = y; start = 1'b1;
    if (push) begin
      e.res = er; e.cout = ec; e.zero = ez; e.ovf = eo; e.name = name;
      e.cyc = cyc + ((o == 3'b100) ? (W + 1) : 1);
      q.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2;
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_cout", 32'(cout), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'(1));

    //     name        op      a      b      push er     ec    ez    eo
    issue("add_ff_01", 3'b000, 8'hFF, 8'h01, 1, 8'h00, 1'b1, 1'b1, 1'b0);
    issue("add_7f_01", 3'b000, 8'h7F, 8'h01, 1, 8'h80, 1'b0, 1'b0, 1'b1);
    issue("sub_05_07", 3'b001, 8'h05, 8'h07, 1, 8'hFE, 1'b0, 1'b0, 1'b0);
    issue("sub_80_01", 3'b001, 8'h80, 8'h01, 1, 8'h7F, 1'b1, 1'b0, 1'b1);
    issue("slt_80_7f", 3'b011, 8'h80, 8'h7F, 1, 8'h01, 1'b0, 1'b0, 1'b0);
    issue("slt_7f_80", 3'b011, 8'h7F, 8'h80, 1, 8'h00, 1'b0, 1'b1, 1'b0);

    issue("mul_13_11", 3'b100, 8'd13, 8'd11, 1, 8'h8F, 1'b0, 1'b0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("mul_busy_cycles", 32'(n), 32'(W + 1));

    // A start pulse while busy must be dropped, not queued.
    issue("mul_ff_ff", 3'b100, 8'hFF, 8'hFF, 1, 8'h01, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("mul_busy_ready", 32'(ready), 32'(0));
    op = 3'b000; a = 8'h01; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Abort a multiply with reset partway through.
    issue("mul_abort", 3'b100, 8'd3, 8'd5, 0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_result", 32'(result), 32'(0));
    chk("abort_cout", 32'(cout), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_ready", 32'(ready), 32'(1));
    repeat (12) @(negedge clk);

    issue("xor_after_rst", 3'b010, 8'hA5, 8'h0F, 1, 8'hAA, 1'b0, 1'b0, 1'b0);
    issue("xor_b2b", 3'b010, 8'hA5, 8'h0F, 1, 8'hAA, 1'b0, 1'b0, 1'b0);
    issue("reserved_110", 3'b110, 8'h5A, 8'h33, 1, 8'h00, 1'b0, 1'b1, 1'b0);

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
